// File: rtl/count_rate_scaler.sv
// rtl/count_rate_scaler.sv - scales a source-domain count by NUM/DEN with saturation
//
// Purpose:
//   Converts a count measured against one clock rate into the equivalent
//   count at another rate: out_count = in_count * NUM / DEN. The product is
//   formed in one cycle, then divided by DEN with a bit-serial restoring
//   divider (one quotient bit per cycle, MSB first). Results that do not fit
//   in OUT_WIDTH bits are clipped to all ones and flagged on out_sat.
//
// Configuration macro:
//   COUNT_SCALER_ROUND_EN - when defined, floor(DEN/2) is added to the
//   product before division (round half up); otherwise the result is
//   truncated. Latency is the same in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_count   in   [WIDTH-1:0] count in the source clock domain
//   in_valid   in   in_count is valid
//   in_ready   out  block can accept a new count (IDLE only)
//   out_count  out  [OUT_WIDTH-1:0] scaled count
//   out_sat    out  out_count was clipped
//   out_valid  out  out_count / out_sat are valid (DONE only)
//   out_ready  in   consumer accepts the result
//
// Latency: out_valid rises on edge PW+1 after the accepting edge, where
//   PW = WIDTH + $clog2(NUM) + 1 (edge 40 for the default parameters).

module count_rate_scaler #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 32,
  parameter int NUM       = 50,
  parameter int DEN       = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_count,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_count,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Product width: wide enough for in_count*NUM plus the rounding bias.
  localparam int PW = WIDTH + $clog2(NUM) + 1;
  // Remainder is always < DEN; RW bits hold it, the shifted trial value
  // needs one more bit.
  localparam int RW = $clog2(DEN + 1);
  localparam int DW = RW + 1;
  localparam int CW = $clog2(PW + 1);
  // Quotient is extended to at least OUT_WIDTH bits so the overflow test
  // and the output slice work whether PW is larger or smaller than OUT_WIDTH.
  localparam int QW = (PW > OUT_WIDTH) ? PW : OUT_WIDTH;

`ifdef COUNT_SCALER_ROUND_EN
  localparam int BIAS = DEN / 2;
`else
  localparam int BIAS = 0;
`endif

  localparam logic [PW-1:0] NUM_P  = PW'(NUM);
  localparam logic [PW-1:0] BIAS_P = PW'(BIAS);
  localparam logic [DW-1:0] DEN_D  = DW'(DEN);
  localparam logic [CW-1:0] LAST   = CW'(PW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  in_hold;
  // During DIV this register shifts left: dividend bits leave at the MSB
  // while quotient bits enter at the LSB, so after PW steps it holds the
  // complete quotient.
  logic [PW-1:0]     work;
  logic [RW-1:0]     rem;
  logic [CW-1:0]     cnt;

  logic [DW-1:0]     rem_shift;
  logic              q_bit;
  logic [RW-1:0]     rem_next;
  logic [PW-1:0]     quot_next;
  logic [QW-1:0]     q_ext;
  logic              sat_next;
  logic [PW-1:0]     product;

  // One restoring-division step plus the saturation test on the quotient
  // that this step would complete.
  always_comb begin
    rem_shift = {rem, work[PW-1]};
    q_bit     = (rem_shift >= DEN_D);
    rem_next  = q_bit ? RW'(rem_shift - DEN_D) : RW'(rem_shift);
    quot_next = {work[PW-2:0], q_bit};
    q_ext     = QW'(quot_next);
    sat_next  = |(q_ext >> OUT_WIDTH);
    product   = PW'(in_hold) * NUM_P + BIAS_P;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_sat   <= 1'b0;
      in_hold   <= '0;
      work      <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_hold  <= in_count;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end

        MUL: begin
          work  <= product;
          rem   <= '0;
          cnt   <= '0;
          state <= DIV;
        end

        DIV: begin
          work <= quot_next;
          rem  <= rem_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            out_sat   <= sat_next;
            out_count <= sat_next ? '1 : q_ext[OUT_WIDTH-1:0];
            state     <= DONE;
          end
        end

        DONE: begin
          // Result holds until the consumer takes it; in_ready stays low
          // so nothing new can be accepted while stalled.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_rate_scaler.sv
// tb/tb_count_rate_scaler.sv - randomized self-checking bench for count_rate_scaler
module tb_count_rate_scaler;

  localparam int NUM = 50;
  localparam int DEN = 27;
  localparam int PW  = 32 + $clog2(NUM) + 1;
`ifdef COUNT_SCALER_ROUND_EN
  localparam int BIAS = DEN / 2;
`else
  localparam int BIAS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_count;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready, in_ready8;
  logic [31:0] out_count;
  logic [7:0]  out_count8;
  logic        out_sat, out_sat8;
  logic        out_valid, out_valid8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  count_rate_scaler #(.WIDTH(32), .OUT_WIDTH(32), .NUM(NUM), .DEN(DEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_count(in_count), .in_valid(in_valid),
    .in_ready(in_ready), .out_count(out_count), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  count_rate_scaler #(.WIDTH(32), .OUT_WIDTH(8), .NUM(NUM), .DEN(DEN)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_count(in_count), .in_valid(in_valid),
    .in_ready(in_ready8), .out_count(out_count8), .out_sat(out_sat8),
    .out_valid(out_valid8), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: scaled value from plain 64-bit arithmetic, clipped to ow bits.
  function automatic void model(input logic [31:0] v, input int ow,
                                output logic [63:0] cnt, output logic sat);
    logic [63:0] q, mx;
    q   = (64'(v) * 64'(NUM) + 64'(BIAS)) / 64'(DEN);
    mx  = (64'd1 << ow) - 64'd1;
    sat = (q > mx);
    cnt = sat ? mx : q;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
  endtask

  // One transaction on both instances; stall = cycles of out_ready=0 in DONE.
  task automatic xact(input logic [31:0] v, input int stall);
    logic [63:0] e32, e8;
    logic s32, s8;
    int lat;
    model(v, 32, e32, s32);
    model(v, 8, e8, s8);
    wait_ready();
    in_count  = v;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      in_count = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(PW + 1));
    check("valid8", 64'(out_valid8), 64'd1);
    check("count32", 64'(out_count), e32);
    check("sat32", 64'(out_sat), 64'(s32));
    check("count8", 64'(out_count8), e8);
    check("sat8", 64'(out_sat8), 64'(s8));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_count = $urandom;
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_count", 64'(out_count), e32);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] v;
    rst_n     = 1'b0;
    in_count  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_sat", 64'(out_sat), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // Directed values
    xact(32'd27, 0);
    xact(32'd1000, 0);
    xact(32'd200, 0);
    xact(32'd100, 0);
    xact(32'd0, 0);
    xact(32'hFFFF_FFFF, 0);
    xact(32'd27, 20);

    // Back-to-back with in_valid held
    wait_ready();
    in_count = 32'd27;
    in_valid = 1'b1;
    out_ready = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    check("b2b_first", 64'(out_count), 64'd50);
    in_count = 32'd54;
    @(negedge clk);
    check("b2b_no_dup", 64'(out_valid), 64'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    check("b2b_second", 64'(out_count), 64'd100);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_end", 64'(out_valid), 64'd0);

    // Reset during DIV
    wait_ready();
    in_count = 32'd27;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_div_valid", 64'(out_valid), 64'd0);
    check("rst_div_count", 64'(out_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_div_ready", 64'(in_ready), 64'd1);
    xact(32'd27, 0);

    // Reset while stalled in DONE with a saturated result
    wait_ready();
    in_count  = 32'hFFFF_FFFF;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    check("done_sat", 64'(out_sat), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_done_valid", 64'(out_valid), 64'd0);
    check("rst_done_sat", 64'(out_sat), 64'd0);
    check("rst_done_count", 64'(out_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Randomized
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: v = 32'($urandom_range(0, 2000));
        1: v = $urandom;
        default: v = 32'd2319282339 + 32'($urandom_range(0, 4)) - 32'd2;
      endcase
      xact(v, int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_rate_scaler.md
COUNT_RATE_SCALER -- requirements
Module: count_rate_scaler

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the input count width in bits.
- REQ-002 The block SHALL have parameter OUT_WIDTH, default 32, meaning the output count width in bits.
- REQ-003 The block SHALL have parameter NUM, default 50, meaning the destination clock rate numerator (integer, >=1).
- REQ-004 The block SHALL have parameter DEN, default 27, meaning the source clock rate denominator (integer, >=1).
- REQ-005 The block SHALL have port clk, input, 1 bit: clock, rising-edge.
- REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-007 The block SHALL have port in_count, input, WIDTH bits: count measured in the source clock domain.
- REQ-008 The block SHALL have port in_valid, input, 1 bit: in_count is valid.
- REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a new count.
- REQ-010 The block SHALL have port out_count, output, OUT_WIDTH bits: the scaled count.
- REQ-011 The block SHALL have port out_sat, output, 1 bit: out_count was clipped.
- REQ-012 The block SHALL have port out_valid, output, 1 bit: out_count and out_sat are valid.
- REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
- REQ-014 The block SHALL compute out_count = in_count*NUM/DEN using an internal product width PW = WIDTH+$clog2(NUM)+1, with no intermediate overflow.
- REQ-015 The block SHALL use a four-state FSM with states IDLE, MUL, DIV and DONE.
- REQ-016 The block SHALL drive in_ready = 1 only in IDLE, and SHALL accept a count on an edge with in_valid && in_ready, latching in_count and moving to MUL.
- REQ-017 In MUL, the block SHALL register the product P = in_count*NUM (plus the rounding bias per REQ-027) in 1 cycle and move to DIV.
- REQ-018 In DIV, the block SHALL perform restoring division by DEN, one quotient bit per cycle, MSB first, for exactly PW cycles, then move to DONE.
- REQ-019 out_valid SHALL be 1 only in DONE; it rises on edge PW+1 counted from the accepting edge (edge 40 for the defaults).
- REQ-020 In DONE, out_count and out_sat SHALL hold stable until the handshake edge (out_valid && out_ready), after which the block returns to IDLE.
- REQ-021 With backpressure (out_ready = 0), the block SHALL stall in DONE indefinitely with no result loss; in_ready stays 0.
- REQ-022 If the quotient exceeds 2^OUT_WIDTH-1, out_count SHALL be all ones and out_sat = 1; otherwise out_sat = 0.
- REQ-023 in_count = 0 SHALL yield out_count = 0, still taking the full latency.
- REQ-024 DEN = 1 SHALL yield the exact product (subject to saturation).
- REQ-025 in_valid asserted outside IDLE SHALL be ignored; in_count changes during computation SHALL NOT affect the result.

Reset
- REQ-026 While rst_n = 0, at any time including mid-DIV or in DONE, the block SHALL asynchronously force state to IDLE, out_count = 0, out_sat = 0 and out_valid = 0; in_ready SHALL be 1 from the first edge after release.

Configuration
- REQ-027 The block SHALL support macro COUNT_SCALER_ROUND_EN:
  - When defined, the block SHALL add floor(DEN/2) to P before division (round half up).
  - When undefined, the block SHALL truncate (floor); the latency is identical in both builds.

Verification
- REQ-028 Defaults, in_count = 27 -> out_count = 50, out_sat = 0, out_valid rising on edge 40 after accept.
- REQ-029 in_count = 1000 -> 1851 without the macro, 1852 with COUNT_SCALER_ROUND_EN.
- REQ-030 OUT_WIDTH = 8, in_count = 200 -> out_count = 255, out_sat = 1; in_count = 100 -> 185, out_sat = 0.
- REQ-031 out_ready held 0 for 20 cycles in DONE, with in_valid pulsed -> result stable, in_ready = 0, no new accept; then out_ready = 1 -> IDLE on the next edge.
- REQ-032 Back-to-back inputs 27 then 54 with in_valid held and out_ready = 1 -> results 50 then 100 in order, with no duplicates.
- REQ-033 rst_n pulsed low during DIV -> outputs immediately 0 and state IDLE; a subsequent in_count = 27 -> 50.
